// File: rtl/cache_miss_controller.sv
// Miss/write-through sequencer between a direct-mapped cache and a 128-bit block memory.
// Optional build macro CACHE_STATS_EN adds saturating read hit/miss counters.
module cache_miss_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 15,
  parameter int CNT_W       = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cpuRead,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddress,
  input  logic [31:0]       cpuWriteData,
  output logic [31:0]       cpuReadData,
  output logic              cpuReady,
  input  logic              cacheHit,
  input  logic [31:0]       cacheWord,
  output logic              cacheFill,
  output logic              cacheUpdate,
  output logic [127:0]      fillData,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memWrite,
  output logic [31:0]       memWriteData,
  input  logic [127:0]      memReadData
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, FILL, WRITE, RESP} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] counter;
  logic [1:0]       wordSel;
  logic             hitQ;
  logic             lastCycle;

  assign lastCycle = (counter == CNT_W'(MEM_LATENCY - 1));

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    nextState   = state;
    cpuReady    = 1'b0;
    cacheFill   = 1'b0;
    cacheUpdate = 1'b0;
    memWrite    = 1'b0;
    case (state)
      IDLE: begin
        if (cpuWrite)     nextState = WRITE;
        else if (cpuRead) nextState = cacheHit ? RESP : FETCH;
      end
      FETCH: if (lastCycle) nextState = FILL;
      FILL: begin
        cacheFill = 1'b1;
        nextState = RESP;
      end
      WRITE: begin
        memWrite = 1'b1;
        if (lastCycle) begin
          cacheUpdate = hitQ;
          nextState   = RESP;
        end
      end
      RESP: begin
        cpuReady  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      wordSel      <= '0;
      hitQ         <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      fillData     <= '0;
      cpuReadData  <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          counter <= '0;
          if (cpuWrite) begin
            memAddress   <= cpuAddress;
            memWriteData <= cpuWriteData;
            hitQ         <= cacheHit;
          end else if (cpuRead) begin
            hitQ    <= cacheHit;
            wordSel <= cpuAddress[1:0];
            if (cacheHit) cpuReadData <= cacheWord;
            else          memAddress  <= {cpuAddress[ADDR_W-1:2], 2'b00};
          end
        end
        FETCH: begin
          counter <= counter + 1'b1;
          if (lastCycle) fillData <= memReadData;
        end
        FILL:  cpuReadData <= fillData[{wordSel, 5'd0} +: 32];
        WRITE: counter <= counter + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Only reads that actually win acceptance are counted; a read dropped for a write is not.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hitCount  <= '0;
      missCount <= '0;
    end else if (state == IDLE && cpuRead && !cpuWrite) begin
      if (cacheHit) begin
        if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
      end else begin
        if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Sequences the 15-bit-address, 4-word-block direct-mapped cache against the 128-bit-wide dataMemory.
- CPU side: one outstanding read/write request with a ready handshake.
- Memory side: block refill on read miss, write-through of single words, no-write-allocate.
- Owns all memWrite/memAddress timing, so cache and memory are never driven directly by the requester.

Parameters:
MEM_LATENCY, 4, cycles a memory access is held before data is valid or a write is committed (legal 1..15)
ADDR_W, 15, word address width
CNT_W, 4, latency counter width

Ports:
clock  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cpuRead  input  1  read request, sampled in IDLE
cpuWrite  input  1  write request, sampled in IDLE
cpuAddress  input  15  word address of request
cpuWriteData  input  32  write data
cpuReadData  output  32  read data, valid while cpuReady=1
cpuReady  output  1  one-cycle completion pulse
cacheHit  input  1  tag-compare result for cpuAddress (combinational from cache)
cacheWord  input  32  word out of cache for cpuAddress
cacheFill  output  1  one-cycle pulse: write fillData into line, set valid/tag
cacheUpdate  output  1  one-cycle pulse: write cpuWriteData word into hit line
fillData  output  128  block to install
memAddress  output  15  memory address
memWrite  output  1  memory write enable
memWriteData  output  32  memory write data
memReadData  input  128  block returned by memory

Behaviour:
- Reset (async): state=IDLE, counter=0; cpuReady, cacheFill, cacheUpdate, memWrite=0; memAddress, memWriteData, fillData, cpuReadData=0. A reset mid-operation drops memWrite immediately, and the request is lost.
- Request acceptance: only in IDLE, at a clock edge with cpuRead|cpuWrite=1. Address, write data and cacheHit are latched at acceptance. Inputs are ignored while busy.
- Read/write priority: if both are high, the write wins and the read is dropped. The requester must re-issue the read.
- States:
  - IDLE:
    - read & hit -> RESP, with cpuReadData <= cacheWord.
    - read & miss -> FETCH, with memAddress <= {addr[14:2],2'b00}, counter=0.
    - write -> WRITE, with memAddress <= addr, memWriteData <= data, counter=0.
  - FETCH: counter increments each cycle. At counter==MEM_LATENCY-1, latch memReadData into fillData -> FILL.
  - FILL: cacheFill=1 for exactly this cycle. cpuReadData <= fillData word selected by addr[1:0] (word 0 = bits 31:0) -> RESP.
  - WRITE: memWrite=1 for exactly MEM_LATENCY cycles. On the last cycle, if the latched hit=1, cacheUpdate=1 -> RESP.
  - RESP: cpuReady=1 for one cycle -> IDLE. A new request can be accepted at the edge leaving RESP+1 (the IDLE cycle).
- Latencies, in cycles from the acceptance edge to the cpuReady high cycle:
  - read hit: 1
  - read miss: MEM_LATENCY+2
  - write: MEM_LATENCY+1
- Memory address is held stable for the whole FETCH/WRITE window. memWrite is never 1 outside WRITE.
- cacheFill and cacheUpdate are mutually exclusive and never high in the same cycle as cpuReady.
- Counter wrap is impossible: it resets on every entry to FETCH/WRITE.
- Addresses: the block-aligned base for refill is valid at address 0x7FFC, with no overflow past 15 bits.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hitCount[15:0] and missCount[15:0].
  - Both counters reset to 0 asynchronously.
  - Counts are taken at read acceptance only. Writes are not counted.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then read 15'd185 with cacheHit=0, MEM_LATENCY=4, memReadData={32'hD,32'hC,32'hB,32'hA}:
  - memAddress=15'd184 for 4 cycles.
  - cacheFill pulse with fillData as given.
  - cpuReady at cycle 6 with cpuReadData=32'hB.
- Read 15'd189 with cacheHit=1, cacheWord=32'h1234 -> cpuReady next cycle, cpuReadData=32'h1234, memWrite=0 throughout.
- Write 15'd1024, data 32'hCAFE, hit=1:
  - memWrite=1 for exactly 4 cycles at memAddress=1024, memWriteData=32'hCAFE.
  - cacheUpdate on the 4th cycle.
  - cpuReady at cycle 5.
- Write with hit=0 -> same memory timing, cacheUpdate never asserted.
- cpuRead=cpuWrite=1 at 15'd7 -> write sequence only, no FETCH.
- rst pulsed during WRITE cycle 2 -> memWrite=0 within the same cycle, state IDLE, all outputs 0.
- (CACHE_STATS_EN) 3 hits then 2 misses -> hitCount=3, missCount=2. Forcing hitCount=16'hFFFF, then one more hit -> hitCount stays at 16'hFFFF.
